// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one fixed-latency synchronous slave port between two valid/ready
//   masters. m0 is normally the CPU and m1 a secondary master such as a
//   loader or DMA engine. Each access walks IDLE -> ISSUE -> WAIT -> RESP:
//   arbitration in IDLE, a single enable cycle in ISSUE, LATENCY wait cycles,
//   then a one-cycle ready pulse to the granted master.
//
// Parameters
//   LATENCY     : slave read latency, enable cycle to valid s_rdata (1..15)
//   ROUND_ROBIN : 1 = alternate grants on contention, 0 = m0 always wins
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   mN_valid/addr/wdata   : master N request, byte address, write data
//   mN_wstrb              : master N byte write enables (0 = read)
//   mN_ready              : master N completion pulse
//   mN_rdata              : master N read data, valid while mN_ready=1
//   s_en                  : slave enable, one cycle per transaction
//   s_addr/s_wdata        : latched address / write data of granted master
//   s_wstrb               : byte enables, non-zero only in the ISSUE cycle
//   s_rdata               : slave read data, LATENCY cycles after s_en
//   grant                 : index of the master currently or last served
//   busy                  : high in every state except IDLE
//
// All outputs are registered.
module mem_bus_arbiter #(
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_en,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        busy
);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);
  localparam bit         RR_EN    = (ROUND_ROBIN != 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_nx;
  logic        last_served;
  logic        last_served_nx;

  logic        req_any;
  logic        sel;

  logic        m0_ready_nx;
  logic        m1_ready_nx;
  logic [31:0] m0_rdata_nx;
  logic [31:0] m1_rdata_nx;
  logic        s_en_nx;
  logic [31:0] s_addr_nx;
  logic [31:0] s_wdata_nx;
  logic [3:0]  s_wstrb_nx;
  logic        grant_nx;
  logic        busy_nx;

  assign req_any = m0_valid | m1_valid;

  // Winner of the IDLE-cycle arbitration. On contention the round-robin
  // variant picks the master that was not served last; last_served resets
  // to 1 so that m0 wins the very first tie.
  always_comb begin
    if (m0_valid && m1_valid) begin
      sel = RR_EN ? ~last_served : 1'b0;
    end else begin
      sel = m1_valid;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_any) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (wait_cnt == 4'd1) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  // The granted byte enables are loaded straight into the s_wstrb register
  // on the IDLE->ISSUE edge and cleared on the next edge, so that register
  // doubles as the wstrb holding register and the slave sees them once.
  always_comb begin
    s_en_nx        = 1'b0;
    s_wstrb_nx     = '0;
    s_addr_nx      = s_addr;
    s_wdata_nx     = s_wdata;
    grant_nx       = grant;
    m0_ready_nx    = 1'b0;
    m1_ready_nx    = 1'b0;
    m0_rdata_nx    = m0_rdata;
    m1_rdata_nx    = m1_rdata;
    wait_cnt_nx    = wait_cnt;
    last_served_nx = last_served;
    busy_nx        = (state_nx != IDLE);

    case (state)
      IDLE: begin
        if (req_any) begin
          grant_nx   = sel;
          s_addr_nx  = sel ? m1_addr  : m0_addr;
          s_wdata_nx = sel ? m1_wdata : m0_wdata;
          s_wstrb_nx = sel ? m1_wstrb : m0_wstrb;
          s_en_nx    = 1'b1;
        end
      end
      ISSUE: begin
        wait_cnt_nx = LAT_LOAD;
      end
      WAIT: begin
        if (wait_cnt == 4'd1) begin
          // Last wait cycle: s_rdata is valid now, capture it so it is
          // presented together with the ready pulse in RESP.
          if (grant) begin
            m1_rdata_nx = s_rdata;
            m1_ready_nx = 1'b1;
          end else begin
            m0_rdata_nx = s_rdata;
            m0_ready_nx = 1'b1;
          end
        end else begin
          wait_cnt_nx = wait_cnt - 4'd1;
        end
      end
      RESP: begin
        last_served_nx = grant;
      end
      default: begin
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s_en        <= 1'b0;
      s_wstrb     <= '0;
      s_addr      <= '0;
      s_wdata     <= '0;
      grant       <= 1'b0;
      busy        <= 1'b0;
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      wait_cnt    <= '0;
      last_served <= 1'b1;
    end else begin
      s_en        <= s_en_nx;
      s_wstrb     <= s_wstrb_nx;
      s_addr      <= s_addr_nx;
      s_wdata     <= s_wdata_nx;
      grant       <= grant_nx;
      busy        <= busy_nx;
      m0_ready    <= m0_ready_nx;
      m1_ready    <= m1_ready_nx;
      m0_rdata    <= m0_rdata_nx;
      m1_rdata    <= m1_rdata_nx;
      wait_cnt    <= wait_cnt_nx;
      last_served <= last_served_nx;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter. Two instances are exercised side by side:
//   dut0: LATENCY=1, ROUND_ROBIN=1
//   dut1: LATENCY=3, ROUND_ROBIN=0
// Each instance has two random masters, a small slave memory, a
// transaction-level reference model that pushes expected transactions into
// a queue, and a monitor that compares the DUT outputs every cycle.
module tb_mem_bus_arbiter;

  typedef struct {
    int          m;
    int          en;
    int          rdy;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
  } txn_t;

  localparam int NTX = 40;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;
  logic fin_d[2];

  always #5 clk = ~clk;

  // cyc changes on the falling edge: at a rising edge it holds the index of
  // the cycle that is ending; one time unit later the new cycle is cyc+1.
  initial forever begin
    @(negedge clk);
    cyc++;
  end

  task automatic chk(input int d, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL dut%0d %s cycle=%0d got=%h expected=%h", d, nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_5A5A ^ (32'(i) * 32'h0101_0101);
  endfunction

  for (genvar d = 0; d < 2; d++) begin : gd
    localparam int unsigned LAT = (d == 0) ? 1 : 3;
    localparam int unsigned RR  = (d == 0) ? 1 : 0;

    logic        mv[2];
    logic [31:0] ma[2];
    logic [31:0] mwd[2];
    logic [3:0]  mws[2];
    logic        mr[2];
    logic [31:0] mrd[2];
    logic        mdone[2];
    logic        mtmo[2];
    logic        s_en, grant, busy;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_rdata = '0;
    logic [3:0]  s_wstrb;
    logic        fin = 1'b0;
    logic        exp_grant = 1'b0;
    txn_t        q[$];

    assign fin_d[d] = fin;

    mem_bus_arbiter #(.LATENCY(LAT), .ROUND_ROBIN(RR)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .m0_valid (mv[0]),
      .m0_addr  (ma[0]),
      .m0_wdata (mwd[0]),
      .m0_wstrb (mws[0]),
      .m0_ready (mr[0]),
      .m0_rdata (mrd[0]),
      .m1_valid (mv[1]),
      .m1_addr  (ma[1]),
      .m1_wdata (mwd[1]),
      .m1_wstrb (mws[1]),
      .m1_ready (mr[1]),
      .m1_rdata (mrd[1]),
      .s_en     (s_en),
      .s_addr   (s_addr),
      .s_wdata  (s_wdata),
      .s_wstrb  (s_wstrb),
      .s_rdata  (s_rdata),
      .grant    (grant),
      .busy     (busy)
    );

    // Random masters: hold the request until ready; sometimes drop valid
    // right after seeing their own enable cycle (allowed by the protocol).
    for (genvar m = 0; m < 2; m++) begin : gm
      logic        v    = 1'b0;
      logic [31:0] a    = '0;
      logic [31:0] wd   = '0;
      logic [3:0]  ws   = '0;
      logic        done = 1'b0;
      logic        tmo  = 1'b0;

      assign mv[m]    = v;
      assign ma[m]    = a;
      assign mwd[m]   = wd;
      assign mws[m]   = ws;
      assign mdone[m] = done;
      assign mtmo[m]  = tmo;

      initial begin : drv
        bit          early, got, drop;
        int unsigned idle;
        repeat (4) @(negedge clk);
        for (int k = 0; k < NTX; k++) begin
          idle = $urandom_range(0, 3);
          repeat (idle) @(negedge clk);
          a  = ($urandom() & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
          wd = $urandom();
          ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
          v  = 1'b1;
          early = ($urandom_range(0, 3) == 0);
          got   = 1'b0;
          drop  = 1'b0;
          for (int c = 0; c < 400 && !got; c++) begin
            @(posedge clk);
            #1;
            if (mr[m]) got = 1'b1;
            else if (reset) drop = 1'b0;
            else if (early && s_en && grant == 1'(m)) drop = 1'b1;
            @(negedge clk);
            v = !drop && !got;
          end
          if (!got) tmo = 1'b1;
          v = 1'b0;
        end
        done = 1'b1;
      end
    end

    // Slave: data is valid only in the cycle exactly LAT after the enable.
    initial begin : slv
      logic [31:0] mem[16];
      int          en_at, s;
      logic [3:0]  en_idx;
      for (int i = 0; i < 16; i++) mem[i] = init_word(i);
      en_at  = -100;
      en_idx = '0;
      forever begin
        @(posedge clk);
        #1;
        s = cyc + 1;
        if (s_en === 1'b1) begin
          en_at  = s;
          en_idx = s_addr[5:2];
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) mem[en_idx][8*b +: 8] = s_wdata[8*b +: 8];
        end
        s_rdata = (s == en_at + int'(LAT)) ? mem[en_idx] : $urandom();
      end
    end

    // Reference model: a transaction granted while the bus is free in cycle
    // e is enabled at e+1, answered at e+LAT+2, and frees the bus at e+LAT+3.
    initial begin : mdl
      logic [31:0] sh[16];
      int          e, free_at, w;
      logic        last;
      logic [3:0]  idx;
      txn_t        t;
      for (int i = 0; i < 16; i++) sh[i] = init_word(i);
      free_at = 0;
      last    = 1'b1;
      forever begin
        @(posedge clk);
        e = cyc;
        if (reset) begin
          q.delete();
          free_at   = e + 1;
          last      = 1'b1;
          exp_grant = 1'b0;
        end else if (e >= free_at && (mv[0] || mv[1])) begin
          if (mv[0] && mv[1]) w = (RR != 0) ? (last ? 0 : 1) : 0;
          else                w = mv[1] ? 1 : 0;
          idx     = ma[w][5:2];
          t.m     = w;
          t.en    = e + 1;
          t.rdy   = e + int'(LAT) + 2;
          t.addr  = ma[w];
          t.wdata = mwd[w];
          t.wstrb = mws[w];
          t.rdata = sh[idx];
          for (int b = 0; b < 4; b++)
            if (t.wstrb[b]) sh[idx][8*b +: 8] = t.wdata[8*b +: 8];
          q.push_back(t);
          free_at   = e + int'(LAT) + 3;
          last      = w[0];
          exp_grant = w[0];
        end
      end
    end

    // Monitor: compares every output each cycle against the queue head.
    initial begin : mon
      txn_t        t;
      bit          have, exp_en, exp_busy, er0, er1;
      int          s, n;
      logic [31:0] exp_rd[2];
      bit          known[2];
      known[0] = 1'b0;
      known[1] = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      n = 0;
      while (!(mdone[0] && mdone[1]) && n < 60000) begin
        @(posedge clk);
        #1;
        n++;
        s = cyc + 1;
        if (reset) begin
          exp_rd[0] = '0;
          exp_rd[1] = '0;
          known[0]  = 1'b1;
          known[1]  = 1'b1;
        end
        have = (q.size() != 0);
        if (have) t = q[0];
        exp_en   = have && s == t.en;
        exp_busy = have && s >= t.en && s <= t.rdy;
        er0      = have && s == t.rdy && t.m == 0;
        er1      = have && s == t.rdy && t.m == 1;
        chk(d, "s_en", 32'(s_en), 32'(exp_en));
        chk(d, "busy", 32'(busy), 32'(exp_busy));
        chk(d, "s_wstrb", 32'(s_wstrb), exp_en ? 32'(t.wstrb) : 32'd0);
        chk(d, "m0_ready", 32'(mr[0]), 32'(er0));
        chk(d, "m1_ready", 32'(mr[1]), 32'(er1));
        chk(d, "grant", 32'(grant), 32'(exp_grant));
        if (exp_en) begin
          chk(d, "s_addr", s_addr, t.addr);
          chk(d, "s_wdata", s_wdata, t.wdata);
        end
        if (have && s == t.rdy) begin
          if (t.wstrb == 4'h0) begin
            exp_rd[t.m] = t.rdata;
            known[t.m]  = 1'b1;
          end else begin
            known[t.m]  = 1'b0;
          end
          void'(q.pop_front());
        end
        if (known[0]) chk(d, "m0_rdata", mrd[0], exp_rd[0]);
        if (known[1]) chk(d, "m1_rdata", mrd[1], exp_rd[1]);
      end
      chk(d, "masters_done", 32'(mdone[0] && mdone[1]), 32'd1);
      chk(d, "m0_timeout", 32'(mtmo[0]), 32'd0);
      chk(d, "m1_timeout", 32'(mtmo[1]), 32'd0);
      chk(d, "queue_empty", 32'(q.size()), 32'd0);
      fin = 1'b1;
    end
  end

  // Main: reset, then a few one-cycle reset pulses at random points while
  // traffic is running, then wait for both monitors to finish.
  initial begin : main
    int c;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(30, 90)) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
    c = 0;
    while (!(fin_d[0] && fin_d[1]) && c < 70000) begin
      @(negedge clk);
      c++;
    end
    chk(2, "bench_complete", 32'(fin_d[0] && fin_d[1]), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
